// File: rtl/ntt_loader_pkg.sv
// ntt_pkg: loader geometry, drain FSM encoding and bank typedefs shared by the loader slice.
// DATA_WIDTH, Q and NTT_STAGE_CNT normally come from ntt.svh; the guarded fallbacks keep the slice standalone.
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef Q
`define Q 3329
`endif
`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif

package ntt_pkg;
    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam int Q          = `Q;
    localparam int N_COEF     = 2 ** `NTT_STAGE_CNT;
    localparam int HALF_N     = N_COEF / 2;
    localparam int COEF_AW    = `NTT_STAGE_CNT;

    typedef logic                  bank_idx_t;
    typedef logic [DATA_WIDTH-1:0] coef_t;
    typedef logic [COEF_AW-1:0]    coef_addr_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;
endpackage

// File: rtl/ntt_loader_if.sv
// ntt_loader_if: coefficient stream in, coefficient-pair stream out towards the ntt core.
// s_valid/s_ready: a word moves on a rising edge where both are high; s_data must be stable while s_valid
// is high. out_en has no back-pressure: every cycle it is high carries one pair the ntt must take.
interface ntt_loader_if #(
    parameter int DW = ntt_pkg::DATA_WIDTH
);
    logic                s_valid;
    logic                s_ready;
    logic [DW-1:0]       s_data;
    logic                out_en;
    logic [1:0][DW-1:0]  out;
    logic                busy;

    modport master (
        output s_valid, s_data,
        input  s_ready, out_en, out, busy
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, out_en, out, busy
    );
endinterface

// File: rtl/ntt_loader_bank.sv
// loader_bank: one polynomial buffer, one write port and two registered read ports (k and k+HALF_N).
// Contents are never reset; the full flags in the loader decide what is meaningful.
module loader_bank
    import ntt_pkg::*;
#(
    parameter int DEPTH = N_COEF,
    parameter int DW    = DATA_WIDTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr0_i,
    input  logic [AW-1:0] raddr1_i,
    output logic [DW-1:0] rdata0_o,
    output logic [DW-1:0] rdata1_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata0_q <= mem_q[raddr0_i];
            rdata1_q <= mem_q[raddr1_i];
        end
    end

    assign rdata0_o = rdata0_q;
    assign rdata1_o = rdata1_q;
endmodule

// File: rtl/ntt_loader.sv
// ntt_loader: ping-pong buffer turning a natural-order coefficient stream into gap-free (k, k+HALF_N) pairs.
// Optional NTT_LOADER_REDUCE_EN folds inputs in [Q, 2^DATA_WIDTH) back below Q on the write path.
module ntt_loader #(
    parameter int N_COEF = ntt_pkg::N_COEF,
    parameter int HALF_N = N_COEF / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    ntt_loader_if.slave           bus,
    output ntt_pkg::drain_state_e dbg_state_o
);
    import ntt_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int AW = $clog2(N_COEF);
    localparam int RW = $clog2(HALF_N);

    logic [1:0]    full_q, full_d;
    bank_idx_t     wr_bank_q, wr_bank_d;
    bank_idx_t     rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [RW-1:0] rd_cnt_q, rd_cnt_d;
    drain_state_e  state_q, state_d;
    logic          s_ready_q;
    logic          out_en_q;
    bank_idx_t     rd_sel_q;

    logic          accept;
    logic          last_wr;
    logic          issue;
    logic          last_rd;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr_lo;
    logic [AW-1:0] raddr_hi;
    logic [DW-1:0] bank_rd0 [2];
    logic [DW-1:0] bank_rd1 [2];

    assign accept  = bus.s_valid && s_ready_q;
    assign last_wr = accept && (wr_cnt_q == AW'(N_COEF - 1));
    assign issue   = (state_q == DRAIN);
    assign last_rd = issue && (rd_cnt_q == RW'(HALF_N - 1));

`ifdef NTT_LOADER_REDUCE_EN
    assign wdata = (bus.s_data >= DW'(Q)) ? bus.s_data - DW'(Q) : bus.s_data;
`else
    assign wdata = bus.s_data;
`endif

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;
        state_d   = state_q;

        if (accept) begin
            wr_cnt_d = last_wr ? '0 : wr_cnt_q + 1'b1;
            if (last_wr) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // The bank being filled is never the one being drained, so set and clear cannot collide.
        if (last_rd) begin
            full_d[rd_bank_q] = 1'b0;
        end

        case (state_q)
            IDLE: begin
                rd_cnt_d = '0;
                if (full_q[rd_bank_q]) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (last_rd) begin
                    rd_cnt_d  = '0;
                    rd_bank_d = ~rd_bank_q;
                    // Chain straight into the other bank when it is already (or just became) full.
                    state_d   = full_d[~rd_bank_q] ? DRAIN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            out_en_q  <= 1'b0;
            rd_sel_q  <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            state_q   <= state_d;
            // Looks at next-state flags so a just-filled bank is never offered to the source.
            s_ready_q <= ~full_d[wr_bank_d];
            out_en_q  <= issue;
            if (issue) begin
                rd_sel_q <= rd_bank_q;
            end
        end
    end

    assign raddr_lo = AW'(rd_cnt_q);
    assign raddr_hi = AW'(rd_cnt_q) + AW'(HALF_N);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        loader_bank #(
            .DEPTH (N_COEF),
            .DW    (DW),
            .AW    (AW)
        ) u_bank (
            .clk      (clk),
            .we_i     (accept && (wr_bank_q == 1'(b))),
            .waddr_i  (wr_cnt_q),
            .wdata_i  (wdata),
            .re_i     (issue && (rd_bank_q == 1'(b))),
            .raddr0_i (raddr_lo),
            .raddr1_i (raddr_hi),
            .rdata0_o (bank_rd0[b]),
            .rdata1_o (bank_rd1[b])
        );
    end

    assign bus.s_ready = s_ready_q;
    assign bus.out_en  = out_en_q;
    assign bus.out[0]  = out_en_q ? bank_rd0[rd_sel_q] : '0;
    assign bus.out[1]  = out_en_q ? bank_rd1[rd_sel_q] : '0;
    assign bus.busy    = (|full_q) | (state_q == DRAIN);
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_ntt_loader.sv
// tb_ntt_loader: table vectors plus scoreboarded polynomial streams for the ping-pong ntt loader.
module tb_ntt_loader;
    import ntt_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int N  = N_COEF;
    localparam int H  = HALF_N;

    typedef logic [DW-1:0] word_t;
    typedef struct {
        word_t din;
        word_t dexp;
        int    pos;
    } vec_t;

`ifdef NTT_LOADER_REDUCE_EN
    localparam word_t E3329 = word_t'(0);
    localparam word_t E3330 = word_t'(1);
    localparam word_t E4095 = word_t'(766);
`else
    localparam word_t E3329 = word_t'(3329);
    localparam word_t E3330 = word_t'(3330);
    localparam word_t E4095 = word_t'(4095);
`endif

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ntt_loader_if bus ();
    drain_state_e dbg_state;

    ntt_loader dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [2*DW-1:0] exp_q[$];
    word_t cur_in  [N];
    word_t cur_exp [N];
    word_t obs     [N];
    int accepted   = 0;
    int pairs_seen = 0;
    int en_runs    = 0;
    int en_hi      = 0;
    int run_len    = 0;
    int bad_runs   = 0;
    int ready_low  = 0;
    bit mon_en     = 1'b0;
    bit prev_en    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic word_t store_of(input word_t x);
`ifdef NTT_LOADER_REDUCE_EN
        return (x >= word_t'(Q)) ? x - word_t'(Q) : x;
`else
        return x;
`endif
    endfunction

    // scoreboard / monitor
    always @(negedge clk) begin
        logic [2*DW-1:0] e;
        if (mon_en) begin
            if (bus.out_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    fail_now("pair_without_expectation");
                end else begin
                    e = exp_q.pop_front();
                    check("pair", 32'(bus.out), 32'(e));
                    obs[pairs_seen % H]     = bus.out[0];
                    obs[pairs_seen % H + H] = bus.out[1];
                end
                pairs_seen++;
                run_len++;
                if (!prev_en) en_runs++;
                en_hi++;
            end else begin
                check("out_zero_idle", 32'(bus.out), 32'(0));
                if (prev_en && run_len != H) bad_runs++;
                run_len = 0;
            end
            if (bus.s_ready !== 1'b1) ready_low++;
            prev_en = (bus.out_en === 1'b1);
        end
    end

    // driver tasks
    task automatic send_word(input word_t d, input int gap_pct);
        int waited = 0;
        bit done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                bus.s_valid = 1'b0;
                bus.s_data  = word_t'($urandom);
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = d;
                if (bus.s_ready === 1'b1) begin
                    done = 1'b1;
                    accepted++;
                end
            end
            waited++;
            if (!done && waited > 4000) begin
                fail_now("send_timeout");
                done = 1'b1;
            end
        end
    endtask

    task automatic feed_poly(input int gap_pct);
        for (int i = 0; i < N; i++) send_word(cur_in[i], gap_pct);
        for (int k = 0; k < H; k++) exp_q.push_back({cur_exp[k+H], cur_exp[k]});
    endtask

    task automatic drive_idle();
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_drained();
        int c = 0;
        @(negedge clk);
        while ((bus.out_en === 1'b1 || bus.busy === 1'b1 || exp_q.size() != 0) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (c >= 3000) fail_now("drain_timeout");
        check("queue_left_after_drain", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        int first;
        int last;
        int hi;
        int c;

        tbl[0] = '{din: word_t'(3329), dexp: E3329,         pos: 0};
        tbl[1] = '{din: word_t'(4095), dexp: E4095,         pos: 128};
        tbl[2] = '{din: word_t'(3328), dexp: word_t'(3328), pos: 1};
        tbl[3] = '{din: word_t'(0),    dexp: word_t'(0),    pos: 129};
        tbl[4] = '{din: word_t'(3330), dexp: E3330,         pos: 2};
        tbl[5] = '{din: word_t'(4095), dexp: E4095,         pos: 255};
        tbl[6] = '{din: word_t'(1),    dexp: word_t'(1),    pos: 127};

        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 32'(bus.s_ready), 32'(0));
        check("rst_out_en", 32'(bus.out_en), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_out", 32'(bus.out), 32'(0));
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b1;
        @(negedge clk);
        check("s_ready_after_release", 32'(bus.s_ready), 32'(1));
        mon_en = 1'b1;

        // single polynomial 0..255 with out_en timing
        for (int i = 0; i < N; i++) begin
            cur_in[i]  = word_t'(i);
            cur_exp[i] = word_t'(i);
        end
        feed_poly(0);
        @(posedge clk);
        first = -1;
        last  = -1;
        hi    = 0;
        for (int n = 0; n <= 131; n++) begin
            @(negedge clk);
            if (n == 0) bus.s_valid = 1'b0;
            if (bus.out_en === 1'b1) begin
                hi++;
                if (first < 0) first = n;
                last = n;
            end
        end
        check("first_out_en_cycle", 32'(first), 32'(2));
        check("last_out_en_cycle", 32'(last), 32'(129));
        check("out_en_high_cycles", 32'(hi), 32'(H));
        wait_drained();

        // table-driven reduction vectors
        for (int i = 0; i < N; i++) begin
            cur_in[i]  = word_t'($urandom_range(0, Q - 1));
            cur_exp[i] = store_of(cur_in[i]);
        end
        for (int t = 0; t < 7; t++) begin
            cur_in[tbl[t].pos]  = tbl[t].din;
            cur_exp[tbl[t].pos] = tbl[t].dexp;
        end
        pairs_seen = 0;
        feed_poly(0);
        drive_idle();
        wait_drained();
        for (int t = 0; t < 7; t++) check("table_word", 32'(obs[tbl[t].pos]), 32'(tbl[t].dexp));

        // back-to-back, s_valid held high across three polynomials
        @(posedge clk);
        en_runs   = 0;
        en_hi     = 0;
        bad_runs  = 0;
        ready_low = 0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < N; i++) begin
                cur_in[i]  = word_t'($urandom_range(0, (1 << DW) - 1));
                cur_exp[i] = store_of(cur_in[i]);
            end
            feed_poly(0);
        end
        drive_idle();
        wait_drained();
        check("b2b_drain_runs", 32'(en_runs), 32'(3));
        check("b2b_out_en_cycles", 32'(en_hi), 32'(3 * H));
        check("b2b_broken_runs", 32'(bad_runs), 32'(0));
        check("b2b_s_ready_low", 32'(ready_low), 32'(0));

        // backpressure: 50% s_valid gaps
        accepted = 0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < N; i++) begin
                cur_in[i]  = word_t'($urandom_range(0, Q - 1));
                cur_exp[i] = store_of(cur_in[i]);
            end
            feed_poly(50);
        end
        drive_idle();
        wait_drained();
        check("accepted_words", 32'(accepted), 32'(3 * N));

        // reset in the middle of a drain
        for (int i = 0; i < N; i++) begin
            cur_in[i]  = word_t'(N - 1 - i);
            cur_exp[i] = word_t'(N - 1 - i);
        end
        pairs_seen = 0;
        feed_poly(0);
        drive_idle();
        c = 0;
        while (pairs_seen < 50 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        if (c >= 1000) fail_now("wait_pair_50");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_out_en", 32'(bus.out_en), 32'(0));
        check("mid_rst_busy", 32'(bus.busy), 32'(0));
        check("mid_rst_s_ready", 32'(bus.s_ready), 32'(0));
        check("mid_rst_out", 32'(bus.out), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", 32'(bus.s_ready), 32'(1));
        check("post_rst_out_en", 32'(bus.out_en), 32'(0));

        for (int i = 0; i < N; i++) begin
            cur_in[i]  = word_t'((i * 7 + 3) % Q);
            cur_exp[i] = store_of(cur_in[i]);
        end
        pairs_seen = 0;
        feed_poly(0);
        drive_idle();
        wait_drained();
        check("fresh_pairs", 32'(pairs_seen), 32'(H));
        check("fresh_pair0_lo", 32'(obs[0]), 32'(cur_exp[0]));
        check("fresh_pair0_hi", 32'(obs[H]), 32'(cur_exp[H]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/ntt_loader.md
NTT_LOADER -- requirements
Module: ntt_loader

Interface
REQ-001 SHALL have parameter: N_COEF, 2**`NTT_STAGE_CNT (256), coefficients per polynomial.
REQ-002 SHALL have parameter: HALF_N, N_COEF/2 (128), pairs emitted per polynomial.
REQ-003 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: s_valid  input  1  input coefficient valid.
REQ-006 SHALL have port: s_ready  output  1  loader can accept a coefficient.
REQ-007 SHALL have port: s_data  input  `DATA_WIDTH  coefficient, natural order 0..N_COEF-1.
REQ-008 SHALL have port: out_en  output  1  pair valid, drives ntt in_en.
REQ-009 SHALL have port: out[2]  output  2x`DATA_WIDTH  pair, drives ntt in.
REQ-010 SHALL have port: busy  output  1  any bank full or draining.

Function
REQ-011 SHALL hold two banks of N_COEF words (ping-pong), with flags full[0:1] and pointers wr_bank and rd_bank.
REQ-012 SHALL drive s_ready as a registered output equal to !full[wr_bank].
REQ-013 SHALL, on a handshake (s_valid && s_ready), write s_data to bank[wr_bank][wr_cnt] and increment wr_cnt.
REQ-014 SHALL, on the handshake with wr_cnt==N_COEF-1, set full[wr_bank], toggle wr_bank and wrap wr_cnt to 0.
REQ-015 SHALL ignore s_data when s_valid is low or s_ready is low; no write and no count change occur.
REQ-016 SHALL implement the drain FSM with two states: IDLE and DRAIN.
REQ-017 SHALL transition IDLE->DRAIN when full[rd_bank]==1, and DRAIN->IDLE when rd_cnt==HALF_N-1 has been issued.
REQ-018 SHALL, in DRAIN, issue read k (k=0..HALF_N-1) so that out[0]=bank[rd_bank][k] and out[1]=bank[rd_bank][k+HALF_N].
REQ-019 SHALL register the read data, giving 1-cycle read latency.
REQ-020 SHALL raise out_en exactly 2 cycles after the edge that accepted coefficient N_COEF-1, when the drain side is idle.
REQ-021 SHALL hold out_en high for exactly HALF_N consecutive cycles with no bubbles, because ntt requires a gap-free stream.
REQ-022 SHALL, on the edge issuing the last read, clear full[rd_bank] and toggle rd_bank.
REQ-023 SHALL let a new drain start on the next cycle if the other bank is already full, giving back-to-back polynomials with zero idle cycles of out_en.
REQ-024 SHALL apply both updates when the full-set of one bank and the full-clear of the other fall on the same edge.
REQ-025 SHALL, when both banks are full, hold s_ready low until the drain clear; s_ready rises on the edge after full[rd_bank] clears.
REQ-026 SHALL drive busy = full[0] | full[1] | (state==DRAIN).
REQ-027 SHALL hold out at 0 whenever out_en is low.

Reset
REQ-028 SHALL, when rst==0 at a clock edge, set state=IDLE, full=0, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, out_en=0, out=0 and busy=0.
REQ-029 SHALL set s_ready=1 on the first edge with rst==1, so s_ready is 0 while in reset.
REQ-030 SHALL, on reset mid-load or mid-drain, abandon the partial polynomial; out_en is 0 from the next cycle.
REQ-031 SHALL NOT require bank RAM contents to be reset.

Configuration
REQ-032 SHALL, with NTT_LOADER_REDUCE_EN defined, store s_data-`Q when s_data>=`Q, else store s_data unchanged (single conditional subtract on the write path, no added latency).
REQ-033 SHALL, without NTT_LOADER_REDUCE_EN, store s_data verbatim; the upstream source then guarantees s_data<`Q.

Structure
REQ-034 SHALL place N_COEF, HALF_N, the drain state enum type (IDLE, DRAIN) and a bank-index typedef in shared package ntt_pkg, while `DATA_WIDTH, `Q and `NTT_STAGE_CNT continue to come from ntt.svh.
REQ-035 SHALL use one sub-module, loader_bank: N_COEF x `DATA_WIDTH RAM with 1 write port and 2 synchronous read ports (addresses k and k+HALF_N), instantiated twice.

Verification
REQ-036 SHALL verify single polynomial: feed 0..255 continuously -> out_en high for cycles 2..129 after the last accept, with pairs (k, k+128) for k=0..127.
REQ-037 SHALL verify back-to-back: feed three polynomials with s_valid held high -> out_en never drops between polynomials, and s_ready drops only when both banks are full.
REQ-038 SHALL verify backpressure: random s_valid gaps (50%) -> identical output pairs; count of accepted words equals 768.
REQ-039 SHALL verify reduction: with NTT_LOADER_REDUCE_EN, input 3329 -> 0 and 4095 -> 766; without the macro, 4095 passes through unchanged.
REQ-040 SHALL verify reset mid-drain: rst=0 at pair 50 -> out_en=0 next cycle, busy=0, s_ready=1 one cycle after release; a fresh polynomial then drains correctly from pair 0.
